// File: rtl/regfile_x31z.sv
// 32 x DATA_W LEGv8 integer register file: two combinational read ports, one synchronous write port, X31 hard-wired to zero.
// Optional build macro REGFILE_BYPASS_EN adds same-cycle write-through forwarding to both read ports.
module regfile_x31z #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [NREG];

    // The zero register gets no flop; every other entry resets to its own index.
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= DATA_W'(i);
                end else if (we3 && (wa3 == ADDR_W'(i))) begin
                    q <= wd3;
                end
            end

            assign regs[i] = q;
        end
    end

    logic fwd1;
    logic fwd2;

`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset so reads show the reset image.
    always_comb begin
        fwd1 = rst_n && we3 && (wa3 != ZERO_ADDR) && (ra1 == wa3);
        fwd2 = rst_n && we3 && (wa3 != ZERO_ADDR) && (ra2 == wa3);
    end
`else
    always_comb begin
        fwd1 = 1'b0;
        fwd2 = 1'b0;
    end
`endif

    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        if (fwd1) rd1 = wd3;
        if (fwd2) rd2 = wd3;
        if (ra1 == ZERO_ADDR) rd1 = '0;
        if (ra2 == ZERO_ADDR) rd2 = '0;
    end

endmodule

// File: tb/tb_regfile_x31z.sv
// Self-checking bench for regfile_x31z: scoreboard queue of expected read values, one task per scenario.
module tb_regfile_x31z;

    logic        clk;
    logic        rst_n;
    logic        we3;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa3;
    logic [63:0] wd3;
    logic [63:0] rd1;
    logic [63:0] rd2;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } sb_t;

    sb_t         sbq[$];
    sb_t         e;
    int          total = 0;
    int          bad   = 0;
    logic [63:0] model [32];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    regfile_x31z #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .we3  (we3),
        .ra1  (ra1),
        .ra2  (ra2),
        .wa3  (wa3),
        .wd3  (wd3),
        .rd1  (rd1),
        .rd2  (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = (i == 31) ? 64'd0 : 64'(i);
    endtask

    task automatic push(input string tag, input logic [63:0] exp);
        sb_t s;
        s.tag = tag;
        s.exp = exp;
        sbq.push_back(s);
    endtask

    function automatic logic [63:0] predict(input logic [4:0] ra);
        if (ra == 5'd31) return 64'd0;
        if (BYPASS && rst_n && we3 && wa3 != 5'd31 && ra == wa3) return wd3;
        return model[ra];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            push("reset_rd1", (i == 31) ? 64'd0 : 64'(i));
            push("reset_rd2", (i == 0) ? 64'd0 : 64'(31 - i));
            #1;
            e = sbq.pop_front(); total++;
            if (rd1 !== e.exp) begin bad++; $display("FAIL %s ra1=%0d got=%h want=%h", e.tag, ra1, rd1, e.exp); end
            e = sbq.pop_front(); total++;
            if (rd2 !== e.exp) begin bad++; $display("FAIL %s ra2=%0d got=%h want=%h", e.tag, ra2, rd2, e.exp); end
        end
    endtask

    task automatic test_we_off();
        @(negedge clk);
        we3 = 1'b0; wa3 = 5'd1; wd3 = 64'h0000_CAFE_CAFE_CAFE; ra2 = 5'd1;
        push("we_off_rd2", 64'd1);
        @(posedge clk); #1;
        e = sbq.pop_front(); total++;
        if (rd2 !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, rd2, e.exp); end
    endtask

    task automatic test_xzr();
        @(negedge clk);
        we3 = 1'b1; wa3 = 5'd31; wd3 = 64'h0000_CAFE_CAFE_CAFE; ra1 = 5'd31; ra2 = 5'd30;
        for (int k = 0; k < 3; k++) begin
            push("xzr_pre_rd1", 64'd0);
            #1;
            e = sbq.pop_front(); total++;
            if (rd1 !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, rd1, e.exp); end
            push("xzr_post_rd1", 64'd0);
            push("xzr_post_rd2", 64'd30);
            @(posedge clk); #1;
            e = sbq.pop_front(); total++;
            if (rd1 !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, rd1, e.exp); end
            e = sbq.pop_front(); total++;
            if (rd2 !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, rd2, e.exp); end
            @(negedge clk);
        end
        we3 = 1'b0;
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        we3 = 1'b1; wa3 = 5'd7; wd3 = 64'hDEAD_BEEF_0123_4567; ra1 = 5'd7; ra2 = 5'd7;
        push("same_pre_rd1", BYPASS ? 64'hDEAD_BEEF_0123_4567 : 64'd7);
        push("same_pre_rd2", BYPASS ? 64'hDEAD_BEEF_0123_4567 : 64'd7);
        #1;
        e = sbq.pop_front(); total++;
        if (rd1 !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, rd1, e.exp); end
        e = sbq.pop_front(); total++;
        if (rd2 !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, rd2, e.exp); end
        push("same_post_rd1", 64'hDEAD_BEEF_0123_4567);
        push("same_post_rd2", 64'hDEAD_BEEF_0123_4567);
        @(posedge clk); #1;
        model[7] = 64'hDEAD_BEEF_0123_4567;
        e = sbq.pop_front(); total++;
        if (rd1 !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, rd1, e.exp); end
        e = sbq.pop_front(); total++;
        if (rd2 !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, rd2, e.exp); end
        @(negedge clk);
        we3 = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            we3 = 1'($urandom_range(0, 3) != 0);
            wa3 = 5'($urandom_range(0, 31));
            wd3 = {32'($urandom), 32'($urandom)};
            ra1 = (k % 4 == 0) ? wa3 : 5'($urandom_range(0, 31));
            ra2 = 5'($urandom_range(0, 31));
            push("b2b_rd1", predict(ra1));
            push("b2b_rd2", predict(ra2));
            #1;
            e = sbq.pop_front(); total++;
            if (rd1 !== e.exp) begin bad++; $display("FAIL %s k=%0d ra1=%0d got=%h want=%h", e.tag, k, ra1, rd1, e.exp); end
            e = sbq.pop_front(); total++;
            if (rd2 !== e.exp) begin bad++; $display("FAIL %s k=%0d ra2=%0d got=%h want=%h", e.tag, k, ra2, rd2, e.exp); end
            @(posedge clk);
            if (we3 && wa3 != 5'd31) model[wa3] = wd3;
        end
        @(negedge clk);
        we3 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            push("b2b_final_rd1", predict(ra1));
            #1;
            e = sbq.pop_front(); total++;
            if (rd1 !== e.exp) begin bad++; $display("FAIL %s ra1=%0d got=%h want=%h", e.tag, ra1, rd1, e.exp); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        we3 = 1'b1; wa3 = 5'd3; wd3 = 64'hFFFF_FFFF_FFFF_FFFF; ra1 = 5'd3;
        @(posedge clk);
        @(negedge clk);
        we3 = 1'b0;
        push("async_before_rd1", 64'hFFFF_FFFF_FFFF_FFFF);
        #1;
        e = sbq.pop_front(); total++;
        if (rd1 !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, rd1, e.exp); end
        #1;
        rst_n = 1'b0;
        push("async_reset_rd1", 64'd3);
        #1;
        e = sbq.pop_front(); total++;
        if (rd1 !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, rd1, e.exp); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset_wins();
        @(negedge clk);
        we3 = 1'b1; wa3 = 5'd4; wd3 = 64'hAA; ra1 = 5'd4; ra2 = 5'd4;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        push("rstwin_during_rd1", 64'd4);
        e = sbq.pop_front(); total++;
        if (rd1 !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, rd1, e.exp); end
        @(negedge clk);
        we3 = 1'b0;
        rst_n = 1'b1;
        model_reset();
        push("rstwin_after_rd1", 64'd4);
        push("rstwin_after_rd2", 64'd4);
        @(posedge clk); #1;
        e = sbq.pop_front(); total++;
        if (rd1 !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, rd1, e.exp); end
        e = sbq.pop_front(); total++;
        if (rd2 !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.tag, rd2, e.exp); end
    endtask

    initial begin
        test_reset();
        test_we_off();
        test_xzr();
        test_same_addr();
        test_back_to_back();
        test_async_reset();
        test_reset_wins();
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_leftover entries=%0d want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
